d_pipe: RTL

//   Parametrised register pipeline: generalises the single D flip-flop into DEPTH

---
 rtl/d_pipe_pkg.sv | 19 +
 rtl/d_pipe_stage.sv | 34 +++
 rtl/d_pipe.sv | 77 +++++++
 3 files changed

// File: rtl/d_pipe_pkg.sv
// Shared definitions for the d_pipe register pipeline: occupancy counter
// width helper and the reset value of the stage data registers.
package d_pipe_pkg;

  // Every data bit takes this value on reset.
  localparam bit RST_DATA_BIT = 1'b0;

  // ceil(log2(n)), never less than 1 so a counter port always has a bit.
  function automatic int unsigned clog2_depth(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One pipeline stage: WIDTH-bit data register, valid bit and the local
// ready term (a stage can take a word when empty or when it is draining).
module d_pipe_stage
  import d_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             ready
);

  assign ready = !valid || dn_ready;

  // Data only moves with a valid word, so an emptied stage keeps its last value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= {WIDTH{RST_DATA_BIT}};
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) data <= up_data;
    end
  end

endmodule

// File: rtl/d_pipe.sv
// DEPTH-stage valid/ready register pipeline with synchronous flush.
// Optional occupancy counter port enabled by defining D_PIPE_OCC_EN.
module d_pipe
  import d_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef D_PIPE_OCC_EN
 ,output logic [clog2_depth(DEPTH+1)-1:0] occupancy
`endif
);

  // Index 0 is the producer side, index DEPTH the consumer side.
  logic             vld [DEPTH+1];
  logic             rdy [DEPTH+1];
  logic [WIDTH-1:0] dat [DEPTH+1];

  assign vld[0]     = in_valid;
  assign dat[0]     = in_data;
  assign rdy[DEPTH] = out_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    d_pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .up_valid (vld[i]),
      .up_data  (dat[i]),
      .dn_ready (rdy[i+1]),
      .valid    (vld[i+1]),
      .data     (dat[i+1]),
      .ready    (rdy[i])
    );
  end

  assign in_ready  = rdy[0] && !flush;
  assign out_valid = vld[DEPTH];
  assign out_data  = dat[DEPTH];

`ifdef D_PIPE_OCC_EN
  localparam int unsigned OCC_W = clog2_depth(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [OCC_W-1:0] occ_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occ_q <= '0;
    end else begin
      unique case ({push, pop})
        2'b10:   occ_q <= occ_q + OCC_W'(1);
        2'b01:   occ_q <= occ_q - OCC_W'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  assign occupancy = occ_q;
`endif

endmodule
